// File: rtl/motion_frame_sequencer_if.sv
// rtl/motion_frame_sequencer_if.sv - frame-buffer read port and subtractor port bundle
//
// Purpose: groups the frame-buffer read signals and the frame-difference
// subtractor handshake seen by motion_frame_sequencer.
// Signals:
//   rd_en, rd_addr          read request to both frame buffers
//   new_pixel, old_pixel    buffer read data, valid 1 cycle after rd_en
//   sub_ready               pixel pair strobe to the subtractor
//   sub_new, sub_old        pixel pair to the subtractor
//   sub_valid, sub_flag     per-pixel result from the subtractor
// Modports: master = sequencer side, slave = buffers/subtractor side.

interface motion_frame_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) ();
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] new_pixel;
    logic [DATA_WIDTH-1:0] old_pixel;
    logic                  sub_ready;
    logic [DATA_WIDTH-1:0] sub_new;
    logic [DATA_WIDTH-1:0] sub_old;
    logic                  sub_valid;
    logic                  sub_flag;

    modport master (
        output rd_en, rd_addr, sub_ready, sub_new, sub_old,
        input  new_pixel, old_pixel, sub_valid, sub_flag
    );

    modport slave (
        input  rd_en, rd_addr, sub_ready, sub_new, sub_old,
        output new_pixel, old_pixel, sub_valid, sub_flag
    );
endinterface

// File: rtl/motion_frame_sequencer.sv
// rtl/motion_frame_sequencer.sv - streams one frame through the subtractor and reports motion
//
// Purpose: on start, issues addresses 0..FRAME_PIXELS-1 to the frame buffers,
// forwards returned pixel pairs to the subtractor, counts flagged pixels and
// reports the count plus a threshold verdict at end of frame.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   start, abort, hold          frame request, cancel, issue stall
//   threshold                   motion threshold, latched on accepted start
//   bus (master)                frame-buffer read port and subtractor port
//   busy, done                  frame in progress, end-of-frame pulse
//   changed_count               flagged pixels in last completed frame
//   motion_detected             changed_count >= latched threshold

module motion_frame_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_PIXELS = 1024,
    parameter int ADDR_WIDTH   = 10,
    parameter int CNT_WIDTH    = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 hold,
    input  logic [CNT_WIDTH-1:0] threshold,
    motion_frame_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] changed_count,
    output logic                 motion_detected
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);
    localparam logic [CNT_WIDTH-1:0]  FRAME_CNT = CNT_WIDTH'(FRAME_PIXELS);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] issue_idx;
    logic [CNT_WIDTH-1:0]  recv_cnt;
    logic [CNT_WIDTH-1:0]  flag_cnt;
    logic [CNT_WIDTH-1:0]  thr_q;
    logic                  ready_q;
    logic                  issue;
    logic                  accept;
    logic [CNT_WIDTH-1:0]  recv_total;

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        // Include this cycle's result so DONE follows the last sub_valid
        // directly instead of waiting a cycle for the register.
        recv_total = recv_cnt + CNT_WIDTH'(bus.sub_valid);
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (!hold) begin
                    issue = 1'b1;
                    if (issue_idx == LAST_ADDR) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (recv_total == FRAME_CNT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                done      = !abort;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.rd_en     = issue;
    assign bus.rd_addr   = issue_idx;
    assign bus.sub_ready = ready_q;
    // Forced to zero outside the strobe so the subtractor inputs stay quiet.
    assign bus.sub_new   = ready_q ? bus.new_pixel : '0;
    assign bus.sub_old   = ready_q ? bus.old_pixel : '0;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            issue_idx       <= '0;
            recv_cnt        <= '0;
            flag_cnt        <= '0;
            thr_q           <= '0;
            ready_q         <= 1'b0;
            changed_count   <= '0;
            motion_detected <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= issue;
            if (accept) begin
                thr_q <= threshold;
            end
            if (state == IDLE) begin
                issue_idx <= '0;
                recv_cnt  <= '0;
                flag_cnt  <= '0;
            end else begin
                if (issue && (issue_idx != LAST_ADDR)) begin
                    issue_idx <= issue_idx + ADDR_WIDTH'(1);
                end
                if (bus.sub_valid) begin
                    recv_cnt <= recv_cnt + CNT_WIDTH'(1);
                    if (bus.sub_flag && (flag_cnt != CNT_MAX)) begin
                        flag_cnt <= flag_cnt + CNT_WIDTH'(1);
                    end
                end
            end
            if (done) begin
                changed_count   <= flag_cnt;
                motion_detected <= (flag_cnt >= thr_q);
            end
        end
    end
endmodule

// File: tb/tb_motion_frame_sequencer.sv
// tb/tb_motion_frame_sequencer.sv - self-checking bench for motion_frame_sequencer

module tb_motion_frame_sequencer;
    localparam int DW = 8;
    localparam int FP = 8;
    localparam int AW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          hold;
    logic [CW-1:0] threshold;
    logic          busy;
    logic          done;
    logic [CW-1:0] changed_count;
    logic          motion_detected;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    motion_frame_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    motion_frame_sequencer #(
        .DATA_WIDTH(DW), .FRAME_PIXELS(FP), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .hold(hold),
        .threshold(threshold), .bus(bus), .busy(busy), .done(done),
        .changed_count(changed_count), .motion_detected(motion_detected)
    );

    // Frame buffers (1-cycle read) and a registered subtractor flagging any difference.
    logic [DW-1:0] new_mem [FP];
    logic [DW-1:0] old_mem [FP];

    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.new_pixel <= new_mem[bus.rd_addr];
            bus.old_pixel <= old_mem[bus.rd_addr];
        end
        bus.sub_valid <= bus.sub_ready;
        bus.sub_flag  <= bus.sub_ready && (bus.sub_new != bus.sub_old);
    end

    typedef struct {
        int            pat;
        logic [CW-1:0] thr;
        int            hold_at;
        int            hold_len;
        int            mid_start;
        bit            done_start;
        int            exp_cnt;
        bit            exp_mot;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_pattern(input int pat);
        logic [DW-1:0] t_new [FP];
        logic [DW-1:0] t_old [FP];
        t_new = '{8'd10, 8'd5, 8'd200, 8'd0, 8'd60, 8'd7, 8'd1, 8'd2};
        t_old = '{8'd100, 8'd5, 8'd100, 8'd0, 8'd9, 8'd7, 8'd1, 8'd2};
        for (int i = 0; i < FP; i++) begin
            case (pat)
                0: begin new_mem[i] = t_new[i]; old_mem[i] = t_old[i]; end
                1: begin new_mem[i] = DW'(i * 3); old_mem[i] = DW'(i * 3); end
                2: begin new_mem[i] = DW'(i); old_mem[i] = DW'(i + 100); end
                default: begin
                    new_mem[i] = DW'($urandom_range(0, 3));
                    old_mem[i] = DW'($urandom_range(0, 3));
                end
            endcase
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < FP; i++) begin
            if (new_mem[i] != old_mem[i]) n++;
        end
        if (n > (1 << CW) - 1) n = (1 << CW) - 1;
        return n;
    endfunction

    task automatic do_frame(input string tag, input logic [CW-1:0] thr, input int hold_at,
                            input int hold_len, input int mid_start, input bit done_start,
                            input int exp_cnt, input bit exp_mot);
        int exp_done;
        int done_cyc;
        int done_n;
        int first_rd;
        int next_addr;
        int ret_idx;
        int hold_rem;
        bit prev_rd;
        bit finished;
        exp_done  = FP + 3 + hold_len;
        done_cyc  = -1;
        done_n    = 0;
        first_rd  = -1;
        next_addr = 0;
        ret_idx   = 0;
        hold_rem  = 0;
        prev_rd   = 1'b0;
        finished  = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; threshold = thr; hold = 1'b0; abort = 1'b0;
        for (int cyc = 1; cyc <= 60 && !finished; cyc++) begin
            @(posedge clk); #1;
            start     = (cyc == mid_start) || (done_start && cyc == exp_done);
            threshold = ~thr;
            hold      = (hold_rem > 0);
            if (hold_rem > 0) hold_rem--;
            @(negedge clk);
            chk({tag, "_sub_ready"}, 32'(bus.sub_ready), 32'(prev_rd));
            if (bus.sub_ready && ret_idx < FP) begin
                chk({tag, "_sub_new"}, 32'(bus.sub_new), 32'(new_mem[ret_idx]));
                chk({tag, "_sub_old"}, 32'(bus.sub_old), 32'(old_mem[ret_idx]));
                ret_idx++;
            end
            prev_rd = bus.rd_en;
            if (bus.rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'(next_addr));
                next_addr++;
                if (int'(bus.rd_addr) == hold_at) hold_rem = hold_len;
            end
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc < 0 || cyc == done_cyc) begin
                chk({tag, "_busy"}, 32'(busy), 32'd1);
            end else begin
                chk({tag, "_busy_after"}, 32'(busy), 32'd0);
                chk({tag, "_rd_en_after"}, 32'(bus.rd_en), 32'd0);
                if (cyc == done_cyc + 1) begin
                    chk({tag, "_changed_count"}, 32'(changed_count), 32'(exp_cnt));
                    chk({tag, "_motion"}, 32'(motion_detected), 32'(exp_mot));
                end
                if (cyc == done_cyc + 3) finished = 1'b1;
            end
        end
        chk({tag, "_first_rd_cycle"}, 32'(first_rd), 32'd1);
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
        chk({tag, "_done_pulses"}, 32'(done_n), 32'd1);
        chk({tag, "_issued"}, 32'(next_addr), 32'(FP));
        chk({tag, "_returned"}, 32'(ret_idx), 32'(FP));
        start = 1'b0; hold = 1'b0;
    endtask

    initial begin
        int found;
        int done_n;
        int exp_c;
        logic [CW-1:0] thr;

        vecs[0] = '{0, 4'd3,  -1, 0, -1, 1'b0, 3, 1'b1};
        vecs[1] = '{0, 4'd4,  -1, 0, -1, 1'b0, 3, 1'b0};
        vecs[2] = '{1, 4'd0,  -1, 0, -1, 1'b0, 0, 1'b1};
        vecs[3] = '{0, 4'd3,   2, 3, -1, 1'b0, 3, 1'b1};
        vecs[4] = '{0, 4'd3,  -1, 0,  4, 1'b1, 3, 1'b1};
        vecs[5] = '{2, 4'd8,  -1, 0, -1, 1'b0, 8, 1'b1};
        vecs[6] = '{2, 4'd15, -1, 0, -1, 1'b0, 8, 1'b0};

        reset = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0; threshold = '0;
        load_pattern(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_en", 32'(bus.rd_en), 32'd0);
        chk("reset_rd_addr", 32'(bus.rd_addr), 32'd0);
        chk("reset_sub_ready", 32'(bus.sub_ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_changed_count", 32'(changed_count), 32'd0);
        chk("reset_motion", 32'(motion_detected), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            load_pattern(vecs[i].pat);
            do_frame($sformatf("row%0d", i), vecs[i].thr, vecs[i].hold_at, vecs[i].hold_len,
                     vecs[i].mid_start, vecs[i].done_start, vecs[i].exp_cnt, vecs[i].exp_mot);
        end

        // Abort at address 4 of a frame that would otherwise report motion.
        load_pattern(2);
        @(posedge clk); #1 start = 1'b1; threshold = 4'd0;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            if (bus.rd_en && bus.rd_addr == 3'd4) begin
                abort = 1'b1;
                found = 1;
            end
        end
        chk("abort_reached_addr4", 32'(found), 32'd1);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rd_en", 32'(bus.rd_en), 32'd0);
        chk("abort_sub_ready", 32'(bus.sub_ready), 32'd0);
        done_n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        chk("abort_no_done", 32'(done_n), 32'd0);
        chk("abort_keep_count", 32'(changed_count), 32'd8);
        chk("abort_keep_motion", 32'(motion_detected), 32'd0);
        load_pattern(0);
        do_frame("after_abort", 4'd3, -1, 0, -1, 1'b0, 3, 1'b1);

        // Asynchronous reset in the middle of FETCH.
        load_pattern(2);
        @(posedge clk); #1 start = 1'b1; threshold = 4'd2;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            if (bus.rd_en && bus.rd_addr == 3'd3) found = 1;
        end
        chk("reset_reached_addr3", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("areset_rd_en", 32'(bus.rd_en), 32'd0);
        chk("areset_rd_addr", 32'(bus.rd_addr), 32'd0);
        chk("areset_sub_ready", 32'(bus.sub_ready), 32'd0);
        chk("areset_sub_new", 32'(bus.sub_new), 32'd0);
        chk("areset_sub_old", 32'(bus.sub_old), 32'd0);
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_done", 32'(done), 32'd0);
        chk("areset_changed_count", 32'(changed_count), 32'd0);
        chk("areset_motion", 32'(motion_detected), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        load_pattern(0);
        do_frame("after_reset", 4'd3, -1, 0, -1, 1'b0, 3, 1'b1);

        // Random frames against the counting model.
        for (int r = 0; r < 20; r++) begin
            load_pattern(3);
            thr   = CW'($urandom_range(0, 9));
            exp_c = model_count();
            do_frame($sformatf("rand%0d", r), thr, -1, 0, -1, 1'b0, exp_c, exp_c >= int'(thr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/motion_frame_sequencer.md
Name: motion_frame_sequencer

Overview:
Sequences one full frame comparison through the frame-difference subtractor. On start it streams pixel addresses 0..FRAME_PIXELS-1 to the new/old frame buffers and forwards the returned pixel pairs to the subtractor with its ready strobe. It collects the subtractor's per-pixel flags, counts changed pixels, and at end of frame reports the count and a motion verdict against a programmable threshold. Sits between the frame-buffer read ports and the subtractor, under control of the capture/host logic.

Parameters:
DATA_WIDTH, 8, pixel width; must match the subtractor's DATA_INPUT
FRAME_PIXELS, 1024, pixels per frame; must be at least 2
ADDR_WIDTH, 10, frame-buffer address width; must satisfy 2^ADDR_WIDTH >= FRAME_PIXELS
CNT_WIDTH, 11, changed-pixel counter width; must satisfy 2^CNT_WIDTH > FRAME_PIXELS

Ports:
clk  in  1  clock, all logic on the rising edge
reset  in  1  asynchronous, active-high
start  in  1  1-cycle request to process a frame; ignored while busy
abort  in  1  cancels the frame in progress
hold  in  1  stall: no new address is issued in a cycle where hold=1
threshold  in  CNT_WIDTH  changed-pixel count at or above which motion is reported; sampled on an accepted start
rd_en  out  1  frame-buffer read enable
rd_addr  out  ADDR_WIDTH  frame-buffer read address, shared by both buffers
new_pixel  in  DATA_WIDTH  new-frame read data, valid 1 cycle after rd_en
old_pixel  in  DATA_WIDTH  old-frame read data, valid 1 cycle after rd_en
sub_ready  out  1  subtractor ready strobe
sub_new  out  DATA_WIDTH  to subtractor new_frame_data
sub_old  out  DATA_WIDTH  to subtractor old_frame_data
sub_valid  in  1  subtractor valid_data
sub_flag  in  1  subtractor frame_difference
busy  out  1  high from an accepted start until done or abort
done  out  1  1-cycle pulse at end of frame
changed_count  out  CNT_WIDTH  flagged pixels in the last completed frame
motion_detected  out  1  changed_count >= threshold for the last completed frame

Behaviour:
- Reset values: rd_en=0, rd_addr=0, sub_ready=0, sub_new=0, sub_old=0, busy=0, done=0, changed_count=0, motion_detected=0. The FSM resets to IDLE, and the internal issue, return and count registers are cleared.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start=1 -> FETCH; busy=1 next cycle; threshold is latched.
  - The internal count is cleared; changed_count and motion_detected hold their previous results.
- FETCH:
  - Each cycle with hold=0, assert rd_en with rd_addr = issue index, then increment the index.
  - With hold=1, rd_en=0 and the index holds.
  - After index FRAME_PIXELS-1 is issued -> DRAIN.
- Read-return stage:
  - sub_ready is rd_en delayed 1 cycle (registered).
  - sub_new = new_pixel and sub_old = old_pixel, passed through combinationally in the sub_ready cycle.
  - Pixels reach the subtractor in address order, one per cycle with no bubbles except those caused by hold.
- Result collection, in every state except IDLE:
  - Each sub_valid=1 increments the received count.
  - If sub_flag=1, the internal changed count also increments; it saturates at 2^CNT_WIDTH-1 and never wraps.
- DRAIN:
  - Wait until received count == FRAME_PIXELS, then go to DONE.
  - hold is ignored.
- DONE (1 cycle):
  - done=1.
  - changed_count <= internal count.
  - motion_detected <= (internal count >= latched threshold), unsigned compare.
  - busy=0 next cycle; -> IDLE.
  - threshold=0 always yields motion_detected=1.
- Latency: with no hold, rd_en is first high the cycle after start, and done pulses FRAME_PIXELS+3 cycles after the start cycle.
- abort:
  - In any non-IDLE state, abort=1 returns the FSM to IDLE next cycle.
  - rd_en and sub_ready are 0 from the next cycle; busy=0; no done pulse.
  - changed_count and motion_detected are unchanged.
  - In-flight sub_valid pulses arriving after the abort are ignored.
  - abort has priority over start in the same cycle.
- start asserted while busy has no effect; there is no queuing.
- start in the DONE cycle is ignored; start is accepted only in IDLE.
- sub_valid while in IDLE is ignored.
- An asynchronous reset mid-frame returns all outputs to reset values immediately; the frame is discarded.

Test Plan:
1. FRAME_PIXELS=8, threshold=3, pixel pairs (10,100),(5,5),(200,100),(0,0),(60,9),(7,7),(1,1),(2,2), subtractor DUT attached -> rd_addr 0..7 on consecutive cycles, done 11 cycles after start, changed_count=3, motion_detected=1.
2. Same data, threshold=4 -> changed_count=3, motion_detected=0; threshold=0 with all-equal pixels -> changed_count=0, motion_detected=1.
3. hold=1 for 3 cycles after addr 2 issued -> addresses 0..7 each issued exactly once in order, sub_ready gap of 3 cycles, done delayed by 3 cycles, count unchanged.
4. abort asserted while rd_addr=4 -> no done pulse, busy=0 next cycle, previous changed_count/motion_detected retained; the next start processes a full frame correctly.
5. start pulsed during FETCH and during DONE -> ignored; exactly one done per accepted start.
6. reset asserted asynchronously mid-FETCH -> all outputs 0 before the next clock edge; a start after reset release gives correct results.
